// File: rtl/mac_mul_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mac_mul_seq_ctrl_pkg
//   Shared definitions for the MAC multiply sequencer: operation-size encodings,
//   controller state encoding, default widths and the size -> step-count helper.
// -----------------------------------------------------------------------------
package mac_mul_seq_ctrl_pkg;

    localparam int MAC_CONF_WIDTH_DEF = 2;
    localparam int MAC_MIN_WIDTH_DEF  = 8;

    // Operation-size encodings carried on in_cfg
    localparam logic [1:0] MAC_CFG_SINGLE = 2'b00;
    localparam logic [1:0] MAC_CFG_DUAL   = 2'b01;
    localparam logic [1:0] MAC_CFG_QUAD   = 2'b10;
    localparam logic [1:0] MAC_CFG_ERR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_t;

    // Number of B lanes consumed for a given size. The illegal encoding still
    // takes one step so its timing matches a single-lane operation.
    function automatic logic [2:0] mac_cfg_steps(input logic [1:0] cfg);
        logic [2:0] n;
        case (cfg)
            MAC_CFG_SINGLE: n = 3'd1;
            MAC_CFG_DUAL:   n = 3'd2;
            MAC_CFG_QUAD:   n = 3'd4;
            default:        n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mac_mul_seq_ctrl_step_mul.sv
// -----------------------------------------------------------------------------
// mac_mul_seq_ctrl_step_mul
//   Combinational unsigned step multiplier: (4*MIN)-bit multiplicand times one
//   MIN-bit multiplier lane, full-precision (5*MIN)-bit product.
// Ports
//   i_a     in   4*MIN  multiplicand
//   i_b     in   MIN    one multiplier lane
//   o_prod  out  5*MIN  i_a * i_b, unsigned, never overflows
// -----------------------------------------------------------------------------
module mac_mul_seq_ctrl_step_mul #(
    parameter int MAC_MIN_WIDTH = 8
) (
    input  logic [4*MAC_MIN_WIDTH-1:0] i_a,
    input  logic [MAC_MIN_WIDTH-1:0]   i_b,
    output logic [5*MAC_MIN_WIDTH-1:0] o_prod
);

    localparam int P_W = 5 * MAC_MIN_WIDTH;

    // Both operands widened to the product width so the multiply is evaluated
    // at full precision.
    assign o_prod = P_W'(i_a) * P_W'(i_b);

endmodule

// File: rtl/mac_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_mul_seq_ctrl
//   Multi-cycle sequencer for the MAC multiply path. Takes one operand pair per
//   in_valid/in_ready handshake, multiplies A by B one byte lane per cycle,
//   shift-adds the lane products into a 64-bit product and optionally adds the
//   product into a running accumulator. The result is held on out_result with
//   out_valid until out_ready.
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/ready    operand handshake
//   in_a, in_b        operands, lanes above the cfg size ignored
//   in_cfg            00 single (8b), 01 dual (16b), 10 quad (32b), 11 error
//   in_acc, in_clr    accumulate enable / clear accumulator before this op
//   out_valid/ready   result handshake
//   out_result        product or acc+product
//   out_err           operation used the illegal size encoding
//   busy              controller not idle
// -----------------------------------------------------------------------------
module mac_mul_seq_ctrl
    import mac_mul_seq_ctrl_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = MAC_CONF_WIDTH_DEF,
    parameter int MAC_MIN_WIDTH  = MAC_MIN_WIDTH_DEF,
    parameter int MAC_ACC_WIDTH  = 8 * MAC_MIN_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4*MAC_MIN_WIDTH-1:0]  in_a,
    input  logic [4*MAC_MIN_WIDTH-1:0]  in_b,
    input  logic [MAC_CONF_WIDTH-1:0]   in_cfg,
    input  logic                        in_acc,
    input  logic                        in_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MAC_ACC_WIDTH-1:0]    out_result,
    output logic                        out_err,
    output logic                        busy
);

    localparam int A_W = 4 * MAC_MIN_WIDTH;
    localparam int P_W = 5 * MAC_MIN_WIDTH;

    mac_state_t                r_state;
    // r_step[1:0] selects the B lane; the counter runs one past the last lane
    // so the final shift-add lands in r_prod before the result is formed.
    logic [2:0]                r_step;
    logic [2:0]                r_n;
    logic [A_W-1:0]            r_a;
    logic [A_W-1:0]            r_b;
    logic                      r_acc_en;
    logic                      r_clr;
    logic                      r_bad_cfg;
    logic [MAC_ACC_WIDTH-1:0]  r_prod;
    logic [MAC_ACC_WIDTH-1:0]  r_acc;
    logic [MAC_ACC_WIDTH-1:0]  r_result;
    logic                      r_valid;
    logic                      r_err;

    logic                      w_accept;
    logic [A_W-1:0]            w_mask;
    logic [MAC_MIN_WIDTH-1:0]  w_b_lane;
    logic [P_W-1:0]            w_partial;
    logic [MAC_ACC_WIDTH-1:0]  w_partial_ext;
    logic [MAC_ACC_WIDTH-1:0]  w_shifted;
    logic [MAC_ACC_WIDTH-1:0]  w_sum;

    assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign busy       = (r_state != ST_IDLE);
    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_err    = r_err;

    mac_mul_seq_ctrl_step_mul #(
        .MAC_MIN_WIDTH (MAC_MIN_WIDTH)
    ) u_step_mul (
        .i_a    (r_a),
        .i_b    (w_b_lane),
        .o_prod (w_partial)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_mask = '0;
        case (in_cfg)
            MAC_CFG_SINGLE: w_mask[MAC_MIN_WIDTH-1:0]   = '1;
            MAC_CFG_DUAL:   w_mask[2*MAC_MIN_WIDTH-1:0] = '1;
            MAC_CFG_QUAD:   w_mask                      = '1;
            default:        w_mask                      = '0;
        endcase

        w_b_lane      = r_b[MAC_MIN_WIDTH*int'(r_step[1:0]) +: MAC_MIN_WIDTH];
        w_partial_ext = {{(MAC_ACC_WIDTH-P_W){1'b0}}, w_partial};
        w_shifted     = w_partial_ext << (MAC_MIN_WIDTH * int'(r_step[1:0]));
        // Clear-then-accumulate: a set clr flag makes the old acc count as 0.
        w_sum         = (r_clr ? '0 : r_acc) + r_prod;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_n       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc_en  <= 1'b0;
            r_clr     <= 1'b0;
            r_bad_cfg <= 1'b0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        // Accepting in DONE (out_ready high) retires the held
                        // result and starts the next op with no idle cycle.
                        r_a       <= in_a & w_mask;
                        r_b       <= in_b & w_mask;
                        r_n       <= mac_cfg_steps(in_cfg);
                        r_bad_cfg <= (in_cfg == MAC_CFG_ERR);
                        r_acc_en  <= in_acc;
                        r_clr     <= in_clr;
                        r_prod    <= '0;
                        r_step    <= '0;
                        r_valid   <= 1'b0;
                        r_err     <= 1'b0;
                        r_state   <= ST_MUL;
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_MUL: begin
                    if (r_step == r_n) begin
                        r_valid <= 1'b1;
                        r_err   <= r_bad_cfg;
                        r_state <= ST_DONE;
                        if (r_bad_cfg) begin
                            // Illegal size: zero result, accumulator untouched.
                            r_result <= '0;
                        end else if (r_acc_en) begin
                            r_result <= w_sum;
                            r_acc    <= w_sum;
                        end else begin
                            r_result <= r_prod;
                            if (r_clr) begin
                                r_acc <= '0;
                            end
                        end
                    end else begin
                        r_prod <= r_prod + w_shifted;
                        r_step <= r_step + 3'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_mul_seq_ctrl
//   Self-checking bench: directed vector table, hand-written handshake/MAC/
//   error/reset sequences and randomized operations against a plain-arithmetic
//   reference model of the multiply-accumulate.
// -----------------------------------------------------------------------------
module tb_mac_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_cfg;
    logic        in_acc;
    logic        in_clr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_err;
    logic        busy;

    mac_mul_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cfg     (in_cfg),
        .in_acc     (in_acc),
        .in_clr     (in_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference accumulator
    longint unsigned m_acc;

    typedef struct {
        string       name;
        logic [1:0]  cfg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int steps_of(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic longint unsigned mask_of(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return 64'hFF;
            2'b01:   return 64'hFFFF;
            2'b10:   return 64'hFFFF_FFFF;
            default: return 64'h0;
        endcase
    endfunction

    // Expected result of one operation; updates the reference accumulator.
    function automatic longint unsigned model_op(input logic [1:0] cfg, input logic [31:0] a,
                                                 input logic [31:0] b, input logic acc_en,
                                                 input logic clr);
        longint unsigned p;
        longint unsigned r;
        if (cfg == 2'b11) return 64'h0;
        p = (longint'(a) & mask_of(cfg)) * (longint'(b) & mask_of(cfg));
        if (acc_en) begin
            r     = (clr ? 64'h0 : m_acc) + p;
            m_acc = r;
        end else begin
            r = p;
            if (clr) m_acc = 64'h0;
        end
        return r;
    endfunction

    // Present a packet at the falling edge and let the next rising edge accept it.
    task automatic issue(input string name, input logic [1:0] cfg, input logic [31:0] a,
                         input logic [31:0] b, input logic acc_en, input logic clr,
                         input logic rdy);
        @(negedge clk);
        in_cfg    = cfg;
        in_a      = a;
        in_b      = b;
        in_acc    = acc_en;
        in_clr    = clr;
        in_valid  = 1'b1;
        out_ready = rdy;
        #1;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = $urandom;
        in_b      = $urandom;
        in_cfg    = 2'($urandom);
        in_acc    = 1'($urandom);
        in_clr    = 1'($urandom);
    endtask

    // Count edges after the accept edge until out_valid, then check outputs.
    task automatic wait_result(input string name, input int exp_lat, input logic [63:0] exp_res,
                               input logic exp_err);
        int lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, out_result, exp_res);
        check({name, " err"}, 64'(out_err), 64'(exp_err));
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " valid drop"}, 64'(out_valid), 64'd0);
        check({name, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] cfg, input logic [31:0] a,
                          input logic [31:0] b, input logic acc_en, input logic clr,
                          input logic [63:0] exp_res, input logic exp_err);
        issue(name, cfg, a, b, acc_en, clr, 1'b0);
        wait_result(name, steps_of(cfg) + 1, exp_res, exp_err);
        release_result(name);
    endtask

    logic [1:0]      r_cfg;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_acc;
    logic            r_clr;
    logic            pending;
    longint unsigned exp_v;
    logic [63:0]     held;

    initial begin
        vecs[0] = '{"single_ff",   2'b00, 32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_FE01, 1'b0};
        vecs[1] = '{"dual",        2'b01, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 1'b0};
        vecs[2] = '{"dual_junk",   2'b01, 32'hDEAD_1234, 32'hBEEF_5678, 64'h0000_0000_0626_0060, 1'b0};
        vecs[3] = '{"quad_max",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
        vecs[4] = '{"single_junk", 2'b00, 32'hABCD_EF02, 32'h1234_5603, 64'h0000_0000_0000_0006, 1'b0};
        vecs[5] = '{"dual_max",    2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b0};
        vecs[6] = '{"quad_lane2",  2'b10, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0};
        vecs[7] = '{"quad_lane1",  2'b10, 32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800, 1'b0};
        vecs[8] = '{"bad_cfg",     2'b11, 32'h0000_0005, 32'h0000_0007, 64'h0,                   1'b1};

        m_acc     = 64'h0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cfg    = '0;
        in_acc    = 1'b0;
        in_clr    = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", out_result, 64'd0);
        check("rst out_err", 64'(out_err), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].cfg, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                   vecs[i].exp, vecs[i].exp_err);
        end

        // Held result: out_ready low for 3 cycles with a new packet stalled
        issue("hold", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait_result("hold", 5, 64'hFFFF_FFFE_0000_0001, 1'b0);
        held = out_result;
        @(negedge clk);
        in_cfg   = 2'b00;
        in_a     = 32'h0000_0002;
        in_b     = 32'h0000_0003;
        in_acc   = 1'b0;
        in_clr   = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold valid", 64'(out_valid), 64'd1);
            check("hold stable", out_result, held);
            check("hold in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stall accept busy", 64'(busy), 64'd1);
        wait_result("stalled pkt", 2, 64'd6, 1'b0);
        release_result("stalled pkt");

        // MAC chain with back-to-back accepts in DONE
        issue("mac1", 2'b10, 32'd3, 32'd5, 1'b1, 1'b1, 1'b0);
        exp_v = model_op(2'b10, 32'd3, 32'd5, 1'b1, 1'b1);
        wait_result("mac1", 5, 64'd15, 1'b0);
        check("mac1 model", 64'(exp_v), out_result);
        issue("mac2", 2'b10, 32'd7, 32'd9, 1'b1, 1'b0, 1'b1);
        check("mac2 no bubble valid", 64'(out_valid), 64'd0);
        check("mac2 no bubble busy", 64'(busy), 64'd1);
        exp_v = model_op(2'b10, 32'd7, 32'd9, 1'b1, 1'b0);
        wait_result("mac2", 5, 64'd78, 1'b0);
        issue("mac3", 2'b10, 32'd2, 32'd2, 1'b1, 1'b0, 1'b1);
        check("mac3 no bubble busy", 64'(busy), 64'd1);
        exp_v = model_op(2'b10, 32'd2, 32'd2, 1'b1, 1'b0);
        wait_result("mac3", 5, 64'd82, 1'b0);
        release_result("mac3");

        // Illegal cfg leaves acc alone (even with acc/clr set); err clears next op
        exp_v = model_op(2'b11, 32'd5, 32'd7, 1'b1, 1'b1);
        run_op("err", 2'b11, 32'd5, 32'd7, 1'b1, 1'b1, exp_v, 1'b1);
        exp_v = model_op(2'b00, 32'd1, 32'd1, 1'b1, 1'b0);
        run_op("after err", 2'b00, 32'd1, 32'd1, 1'b1, 1'b0, exp_v, 1'b0);
        check("after err acc", 64'(exp_v), 64'd83);

        // clr without acc: result is the product, acc cleared
        exp_v = model_op(2'b00, 32'd3, 32'd3, 1'b0, 1'b1);
        run_op("clr only", 2'b00, 32'd3, 32'd3, 1'b0, 1'b1, exp_v, 1'b0);
        exp_v = model_op(2'b00, 32'd1, 32'd1, 1'b1, 1'b0);
        run_op("after clr", 2'b00, 32'd1, 32'd1, 1'b1, 1'b0, 64'd1, 1'b0);

        // Randomized operations against the reference model
        pending = 1'b0;
        for (int i = 0; i < 60; i++) begin
            r_cfg = 2'($urandom_range(0, 3));
            r_a   = $urandom;
            r_b   = $urandom;
            r_acc = 1'($urandom);
            r_clr = ($urandom_range(0, 4) == 0);
            if (pending && ($urandom_range(0, 1) == 0)) begin
                release_result("rand release");
                pending = 1'b0;
            end
            issue("rand", r_cfg, r_a, r_b, r_acc, r_clr, pending);
            exp_v = model_op(r_cfg, r_a, r_b, r_acc, r_clr);
            wait_result("rand", steps_of(r_cfg) + 1, exp_v, (r_cfg == 2'b11));
            pending = 1'b1;
            held    = out_result;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                @(posedge clk);
                #1;
                check("rand hold", out_result, held);
            end
        end
        if (pending) release_result("rand final");

        // Reset in the middle of a quad op (at step 2)
        exp_v = model_op(2'b00, 32'd9, 32'd9, 1'b1, 1'b1);
        run_op("pre rst", 2'b00, 32'd9, 32'd9, 1'b1, 1'b1, 64'd81, 1'b0);
        issue("mid rst", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mid rst busy before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst in_ready", 64'(in_ready), 64'd1);
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst out_result", out_result, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        m_acc = 64'h0;
        exp_v = model_op(2'b00, 32'd4, 32'd5, 1'b1, 1'b0);
        run_op("post rst acc", 2'b00, 32'd4, 32'd5, 1'b1, 1'b0, 64'd20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
